// File: rtl/ser2par_pkg.sv
// Shared types and constants for the ser2par_loader serial-to-parallel front end.
package ser2par_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_PAR   = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      PAR   = ST_PAR
   } state_t;

   // Bit-counter width for an n-bit word; at least one bit for tiny widths.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ser2par_bitcnt.sv
// Received-bit counter: clear wins over increment; last flags the final data bit.
module ser2par_bitcnt #(
   parameter int N  = 30,
   parameter int CW = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic last
);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clr) begin
         count_reg <= '0;
      end else if (inc) begin
         count_reg <= count_reg + CW'(1);
      end
   end

   assign last = (count_reg == CW'(N - 1));

endmodule

// File: rtl/ser2par_loader.sv
// Assembles an N-bit word from an LSB-first serial stream framed by start pulses.
// Define SER2PAR_PARITY_CHECK_EN to require a trailing even-parity bit per frame.
module ser2par_loader
   import ser2par_pkg::*;
#(
   parameter int N  = 30,
   parameter int CW = cnt_width(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         sin_valid,
   input  logic         sin_data,
   output logic [N-1:0] d_out,
   output logic         en_out,
   output logic         busy,
   output logic         frame_err
);

   state_t       state_reg, state_next;
   logic [N-1:0] sr_reg, sr_next;
   logic [N-1:0] d_reg, d_next;
   logic [N-1:0] shifted;
   logic         en_reg, en_next;
   logic         err_reg, err_next;
   logic         busy_reg;
   logic         cnt_clr, cnt_inc, cnt_last;

   assign shifted = {sin_data, sr_reg[N-1:1]};

   ser2par_bitcnt #(.N(N), .CW(CW)) u_bitcnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .last  (cnt_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         sr_reg    <= '0;
         d_reg     <= '0;
         en_reg    <= 1'b0;
         err_reg   <= 1'b0;
         busy_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         sr_reg    <= sr_next;
         d_reg     <= d_next;
         en_reg    <= en_next;
         err_reg   <= err_next;
         busy_reg  <= (state_next != IDLE);
      end
   end

   always_comb begin
      state_next = state_reg;
      sr_next    = sr_reg;
      d_next     = d_reg;
      en_next    = 1'b0;
      err_next   = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = SHIFT;
               sr_next    = '0;
               cnt_clr    = 1'b1;
            end
         end
         SHIFT: begin
            // A restart outranks a data bit arriving in the same cycle.
            if (start) begin
               err_next = 1'b1;
               sr_next  = '0;
               cnt_clr  = 1'b1;
            end else if (sin_valid) begin
               sr_next = shifted;
               if (cnt_last) begin
                  cnt_clr = 1'b1;
`ifdef SER2PAR_PARITY_CHECK_EN
                  state_next = PAR;
`else
                  state_next = IDLE;
                  d_next     = shifted;
                  en_next    = 1'b1;
`endif
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
`ifdef SER2PAR_PARITY_CHECK_EN
         PAR: begin
            if (start) begin
               state_next = SHIFT;
               err_next   = 1'b1;
               sr_next    = '0;
               cnt_clr    = 1'b1;
            end else if (sin_valid) begin
               // Even parity: data ones plus the parity bit must be even.
               state_next = IDLE;
               if ((^sr_reg) == sin_data) begin
                  d_next  = sr_reg;
                  en_next = 1'b1;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
`endif
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign d_out     = d_reg;
   assign en_out    = en_reg;
   assign busy      = busy_reg;
   assign frame_err = err_reg;

endmodule

// File: tb/tb_ser2par_loader.sv
// Directed bench for ser2par_loader at N=8; adds parity cases when SER2PAR_PARITY_CHECK_EN is set.
`timescale 1ns/1ps
module tb_ser2par_loader;

   localparam int N = 8;
`ifdef SER2PAR_PARITY_CHECK_EN
   localparam int NB = N + 1;
`else
   localparam int NB = N;
`endif

   logic         clk;
   logic         reset;
   logic         start;
   logic         sin_valid;
   logic         sin_data;
   logic [N-1:0] d_out;
   logic         en_out;
   logic         busy;
   logic         frame_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int en_cnt = 0, err_cnt = 0, both_cnt = 0;
   int en_cyc = 0, start_cyc = 0;

   ser2par_loader #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .sin_valid (sin_valid),
      .sin_data  (sin_data),
      .d_out     (d_out),
      .en_out    (en_out),
      .busy      (busy),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (en_out) begin
            en_cnt++;
            en_cyc = cyc;
         end
         if (frame_err) err_cnt++;
         if (en_out && frame_err) both_cnt++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish (got timeout, need finish)");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      sin_valid = 1'b1;
      sin_data  = b;
      tick();
      sin_valid = 1'b0;
      sin_data  = 1'b0;
   endtask

   task automatic drive_gap(input int n);
      sin_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic do_start();
      start     = 1'b1;
      start_cyc = cyc;
      tick();
      start     = 1'b0;
   endtask

   task automatic send_word(input logic [N-1:0] w, input int g, input logic pbit);
      for (int i = 0; i < N; i++) begin
         drive_bit(w[i]);
         if (i < NB - 1) drive_gap(g);
      end
`ifdef SER2PAR_PARITY_CHECK_EN
      drive_bit(pbit);
`endif
   endtask

   initial begin
      int e0, r0, first_en;
      logic [N-1:0] w;
      reset = 1'b1; start = 1'b0; sin_valid = 1'b0; sin_data = 1'b0;
      repeat (3) tick();
      chk("rst_d_out", 32'(d_out), 32'h0);
      chk("rst_en", 32'(en_out), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_err", 32'(frame_err), 32'h0);
      reset = 1'b0;
      tick();

      // Valid bits while idle must not start or disturb anything.
      sin_valid = 1'b1; sin_data = 1'b1;
      repeat (3) tick();
      sin_valid = 1'b0;
      chk("idle_busy", 32'(busy), 32'h0);

      // Basic contiguous frame: 1,0,1,1,0,0,1,0 -> 0x4D.
      w = 8'h4D;
      e0 = en_cnt;
      do_start();
      chk("basic_busy", 32'(busy), 32'h1);
      send_word(w, 0, ^w);
      chk("basic_en", 32'(en_out), 32'h1);
      chk("basic_d", 32'(d_out), 32'h4D);
      chk("basic_busy_fall", 32'(busy), 32'h0);
      tick();
      chk("basic_en_1cyc", 32'(en_out), 32'h0);
      chk("basic_en_cnt", 32'(en_cnt - e0), 32'd1);
      chk("basic_lat", 32'(en_cyc - start_cyc), 32'(NB + 1));

      // Two idle cycles between every bit.
      e0 = en_cnt;
      do_start();
      send_word(w, 2, ^w);
      chk("gap_en", 32'(en_out), 32'h1);
      chk("gap_d", 32'(d_out), 32'h4D);
      tick();
      chk("gap_lat", 32'(en_cyc - start_cyc), 32'(NB + 1 + 2 * (NB - 1)));
      chk("gap_en_cnt", 32'(en_cnt - e0), 32'd1);

      // Abort after five bits, restart, then receive 0xA5.
      e0 = en_cnt; r0 = err_cnt;
      do_start();
      repeat (5) drive_bit(1'b1);
      do_start();
      chk("abort_err", 32'(frame_err), 32'h1);
      chk("abort_d_held", 32'(d_out), 32'h4D);
      chk("abort_busy", 32'(busy), 32'h1);
      w = 8'hA5;
      send_word(w, 0, ^w);
      chk("abort_en", 32'(en_out), 32'h1);
      chk("abort_d", 32'(d_out), 32'hA5);
      tick();
      chk("abort_err_cnt", 32'(err_cnt - r0), 32'd1);
      chk("abort_en_cnt", 32'(en_cnt - e0), 32'd1);
      chk("abort_lat", 32'(en_cyc - start_cyc), 32'(NB + 1));

      // Back-to-back: second start coincides with the first load strobe.
      e0 = en_cnt;
      w = 8'h01;
      do_start();
      send_word(w, 0, ^w);
      chk("b2b_en1", 32'(en_out), 32'h1);
      chk("b2b_d1", 32'(d_out), 32'h01);
      first_en = cyc;
      do_start();
      w = 8'hFF;
      send_word(w, 0, ^w);
      chk("b2b_en2", 32'(en_out), 32'h1);
      chk("b2b_d2", 32'(d_out), 32'hFF);
      tick();
      chk("b2b_gap", 32'(en_cyc - first_en), 32'(NB + 1));
      chk("b2b_en_cnt", 32'(en_cnt - e0), 32'd2);

      // Reset mid-frame after three bits, then a clean frame.
      do_start();
      repeat (3) drive_bit(1'b1);
      e0 = en_cnt; r0 = err_cnt;
      reset = 1'b1;
      #1;
      chk("mrst_busy", 32'(busy), 32'h0);
      chk("mrst_d", 32'(d_out), 32'h0);
      tick();
      reset = 1'b0;
      repeat (2) tick();
      chk("mrst_no_en", 32'(en_cnt - e0), 32'd0);
      chk("mrst_no_err", 32'(err_cnt - r0), 32'd0);
      w = 8'h3C;
      sin_valid = 1'b1; sin_data = 1'b1;
      do_start();
      sin_valid = 1'b0;
      send_word(w, 0, ^w);
      chk("mrst_en", 32'(en_out), 32'h1);
      chk("mrst_d_new", 32'(d_out), 32'h3C);
      tick();

`ifdef SER2PAR_PARITY_CHECK_EN
      // Good parity loads; bad parity flags an error and keeps d_out.
      w = 8'h4D;
      do_start();
      send_word(w, 0, 1'b0);
      chk("par_ok_en", 32'(en_out), 32'h1);
      chk("par_ok_d", 32'(d_out), 32'h4D);
      tick();
      w = 8'hA5;
      do_start();
      send_word(w, 0, 1'b0);
      chk("par_ok2_d", 32'(d_out), 32'hA5);
      tick();
      w = 8'h4D;
      e0 = en_cnt;
      do_start();
      send_word(w, 0, 1'b1);
      chk("par_bad_err", 32'(frame_err), 32'h1);
      chk("par_bad_en", 32'(en_out), 32'h0);
      chk("par_bad_d", 32'(d_out), 32'hA5);
      tick();
      chk("par_bad_en_cnt", 32'(en_cnt - e0), 32'd0);
      chk("par_bad_idle", 32'(busy), 32'h0);
`endif

      chk("en_err_exclusive", 32'(both_cnt), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ser2par_loader.md
# ser2par_loader

Serial-to-parallel front end that assembles an N-bit word from a 1-bit stream and presents it with a one-cycle load strobe. It sits directly upstream of the team's N-bit enable register: `d_out` drives the register's `d` and `en_out` drives its `en`. Framing is marked by a `start` pulse; bits may arrive with gaps.

## Interface
- `N`, default 30: word width; must be ≥ 2.
- `CW`, default `$clog2(N)`: bit-counter width; derived, never overridden.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state and outputs.
- `start`  in  1  frame-start pulse; the start cycle carries no data bit.
- `sin_valid`  in  1  `sin_data` is valid this cycle.
- `sin_data`  in  1  serial data bit, LSB first.
- `d_out`  out  N  last completed word; held between loads.
- `en_out`  out  1  one-cycle load strobe for the downstream register.
- `busy`  out  1  high while a frame is being received.
- `frame_err`  out  1  one-cycle pulse on an aborted or bad frame.

## Operation
- States:
  - IDLE
  - SHIFT
  - PAR (present only with the parity option).
- IDLE:
  - `start=1` → SHIFT, with count=0 and the shift register cleared.
  - `sin_valid` is ignored in IDLE, including in the start cycle.
- SHIFT, with `sin_valid=1`:
  - Shift right: `sr <= {sin_data, sr[N-1:1]}`. The first received bit ends up at `d_out[0]`.
  - Increment count.
- SHIFT, with `sin_valid=0`: hold all state (gap).
- Bit N (count==N-1 and valid):
  - Without parity: `d_out <=` assembled word, `en_out <= 1`, → IDLE.
  - With parity: → PAR.
- `start=1` while in SHIFT or PAR:
  - Abort the frame and discard partial data.
  - Pulse `frame_err`; `d_out` is unchanged.
  - Restart the frame: → SHIFT, count=0. This takes priority over a valid bit in the same cycle.
- `busy` = (state != IDLE).
- `en_out` and `frame_err` are never high in the same cycle.
- `d_out` changes only on a successful load.

## Timing
- Reset values:
  - `d_out=0`, `en_out=0`, `busy=0`, `frame_err=0`.
  - state=IDLE, count=0.
- All outputs are registered.
- Latency: `en_out` is high in the cycle after the edge that accepts the final bit (data or parity). With no gaps, that is N+1 cycles after `start` (N+2 with parity).
- Back-to-back frames: `start` may be asserted in the same cycle `en_out` is high. Minimum frame period is N+1 cycles (N+2 with parity).
- `reset` asserted mid-frame discards the frame. No `en_out` or `frame_err` is emitted.
- Count wrap-around never occurs: count resets on completion or abort.

## Configuration
- `SER2PAR_PARITY_CHECK_EN` defined:
  - After the N data bits, one more valid bit is accepted in PAR as even parity.
  - Match: load `d_out`, pulse `en_out`.
  - Mismatch: pulse `frame_err`, no load, `d_out` unchanged.
  - Both cases → IDLE.
  - Gaps in PAR hold state; `start` in PAR aborts as in SHIFT.
- Not defined: no PAR state and no parity logic. `frame_err` pulses only on abort.

## Structure
- Package `ser2par_pkg`:
  - State enum (IDLE, SHIFT, PAR).
  - Encoding constants.
  - Counter-width helper function.
- One sub-module, `ser2par_bitcnt`: CW-bit counter with clear, increment-on-valid and `last` flag (count==N-1). It is reused for the abort/restart clear.

## Test plan
- Reset, N=8: after reset, all outputs are 0 and `busy=0`. Assert `reset` mid-frame after 3 bits → no `en_out`, and a fresh frame loads correctly.
- Basic frame, N=8: `start`, then bits 1,0,1,1,0,0,1,0 contiguous → `en_out` one cycle, 9 cycles after `start`; `d_out=8'h4D`; `busy` falls the same cycle.
- Gaps: the same bits with `sin_valid` low for 2 cycles between each bit → same `d_out=8'h4D`, with `en_out` delayed by exactly 14 cycles.
- Abort: `start`, 5 bits, then `start` again, then 8 bits of `8'hA5` → one `frame_err` pulse at the second start; a single `en_out` with `d_out=8'hA5`; the prior `d_out` is held until then.
- Back-to-back: two frames, `8'h01` then `8'hFF`, with the second `start` coincident with the first `en_out` → two `en_out` pulses 9 cycles apart, with correct words.
- `SER2PAR_PARITY_CHECK_EN`, N=8: `8'h4D` with parity bit 0 → load, `d_out=8'h4D`. `8'h4D` with parity bit 1 → `frame_err` pulse, no `en_out`, `d_out` unchanged.
